redmule_x_buffer_ctrl: RTL and testbench



---
 rtl/redmule_x_buffer_ctrl.sv | 129 ++++++++++++
 tb/tb_redmule_x_buffer_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/redmule_x_buffer_ctrl.sv
// redmule_x_buffer_ctrl: sequences X-buffer tile loads, pad setup and column shifts for a programmed number of tiles per job.
module redmule_x_buffer_ctrl #(
  parameter  int unsigned DW        = 256,
  parameter  int unsigned BITW      = 16,
  parameter  int unsigned W         = 12,
  parameter  int unsigned H         = 4,
  parameter  int unsigned TOT_DEPTH = H * (DW / (H * BITW)),
  parameter  int unsigned TILE_W    = 16,
  localparam int unsigned WW        = $clog2(W) + 1,
  localparam int unsigned HW        = $clog2(TOT_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [WW-1:0]     cfg_width_i,
  input  logic [HW-1:0]     cfg_height_i,
  input  logic [TILE_W-1:0] cfg_tiles_i,
  input  logic              x_valid_i,
  output logic              x_ready_o,
  input  logic              shift_req_i,
  output logic              shift_gnt_o,
  input  logic              full_i,
  input  logic              empty_i,
  output logic              load_o,
  output logic              pad_setup_o,
  output logic              h_shift_o,
  output logic              rst_w_index_o,
  output logic [WW-1:0]     width_o,
  output logic [HW-1:0]     height_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [TILE_W-1:0] tile_cnt_o
);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STREAM, DONE} state_e;
  localparam logic [WW-1:0] W_MAX = WW'(W);
  localparam logic [HW-1:0] H_MAX = HW'(TOT_DEPTH);
  state_e            state_q, state_d;
  logic [WW-1:0]     width_q, width_d;
  logic [HW-1:0]     height_q, height_d, shift_cnt_q, shift_cnt_d;
  logic [TILE_W-1:0] tiles_q, tiles_d, tile_cnt_q, tile_cnt_d;
  logic              err_q, err_d;
  logic              illegal, last_shift, last_tile;
  assign illegal    = (cfg_width_i == '0) || (cfg_width_i > W_MAX) ||
                      (cfg_height_i == '0) || (cfg_height_i > H_MAX) || (cfg_tiles_i == '0);
  assign last_shift = shift_cnt_q == height_q - HW'(1);
  assign last_tile  = tile_cnt_q + TILE_W'(1) == tiles_q;
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    tiles_d     = tiles_q;
    shift_cnt_d = shift_cnt_q;
    tile_cnt_d  = tile_cnt_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        if (illegal) err_d = 1'b1;
        else begin
          width_d     = cfg_width_i;
          height_d    = cfg_height_i;
          tiles_d     = cfg_tiles_i;
          shift_cnt_d = '0;
          tile_cnt_d  = '0;
          state_d     = LOAD;
        end
      end
      LOAD: state_d = (x_valid_i && full_i) ? SETUP : LOAD;
      SETUP: begin
        shift_cnt_d = '0;
        state_d     = STREAM;
      end
      STREAM: if (shift_req_i) begin
        shift_cnt_d = shift_cnt_q + HW'(1);
        // the buffer must report empty exactly on the tile's final column
        if (last_shift != empty_i) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (last_shift) begin
          tile_cnt_d = tile_cnt_q + TILE_W'(1);
          state_d    = last_tile ? DONE : LOAD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d     = IDLE;
      width_d     = '0;
      height_d    = '0;
      tiles_d     = '0;
      shift_cnt_d = '0;
      tile_cnt_d  = '0;
      err_d       = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      tiles_q     <= '0;
      shift_cnt_q <= '0;
      tile_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      tiles_q     <= tiles_d;
      shift_cnt_q <= shift_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
      err_q       <= err_d;
    end
  end
  assign x_ready_o     = state_q == LOAD;
  assign load_o        = x_ready_o && x_valid_i;
  assign shift_gnt_o   = (state_q == STREAM) && shift_req_i;
  assign h_shift_o     = shift_gnt_o;
  assign pad_setup_o   = state_q == SETUP;
  assign rst_w_index_o = pad_setup_o;
  assign busy_o        = state_q != IDLE;
  assign done_o        = state_q == DONE;
  assign err_o         = err_q;
  assign width_o       = width_q;
  assign height_o      = height_q;
  assign tile_cnt_o    = tile_cnt_q;
endmodule

// File: tb/tb_redmule_x_buffer_ctrl.sv
// tb_redmule_x_buffer_ctrl: random-stimulus bench with a tile-level buffer/job model.
module tb_redmule_x_buffer_ctrl;
  localparam int W = 4, TD = 8, TW = 16;
  localparam int WW = $clog2(W) + 1, HW = $clog2(TD) + 1;
  logic clk = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
  logic [WW-1:0] cfg_width_i = '0, width_o;
  logic [HW-1:0] cfg_height_i = '0, height_o;
  logic [TW-1:0] cfg_tiles_i = '0, tile_cnt_o;
  logic x_valid_i = 1'b0, shift_req_i = 1'b0, full_i = 1'b0, empty_i = 1'b0;
  logic x_ready_o, shift_gnt_o, load_o, pad_setup_o, h_shift_o, rst_w_index_o, busy_o, done_o, err_o;
  int n_chk = 0, n_pass = 0;

  redmule_x_buffer_ctrl #(.DW(128), .BITW(16), .W(W), .H(2), .TOT_DEPTH(TD), .TILE_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i), .cfg_tiles_i(cfg_tiles_i),
    .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .shift_req_i(shift_req_i), .shift_gnt_o(shift_gnt_o),
    .full_i(full_i), .empty_i(empty_i), .load_o(load_o), .pad_setup_o(pad_setup_o),
    .h_shift_o(h_shift_o), .rst_w_index_o(rst_w_index_o), .width_o(width_o), .height_o(height_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .tile_cnt_o(tile_cnt_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [31:0] outs();
    return {load_o, pad_setup_o, h_shift_o, rst_w_index_o, busy_o, done_o, err_o, x_ready_o, shift_gnt_o,
            width_o, height_o, tile_cnt_o};
  endfunction

  // bad>0: buffer reports empty on grant #bad; clr>0: clear_i with a request after clr grants
  task automatic run_job(input int wd, ht, tl, pv, pr, bad, clr);
    int rows = 0, grants = 0, tiles_done = 0, n_ld = 0, n_sh = 0, n_su = 0, t_end = 0;
    bit in_stream = 0, fin = 0, got_err = 0, done_at_end = 0;
    @(negedge clk);
    cfg_width_i = WW'(wd); cfg_height_i = HW'(ht); cfg_tiles_i = TW'(tl);
    start_i = 1; x_valid_i = 0; shift_req_i = 0; full_i = 0; empty_i = 0;
    @(negedge clk);
    start_i = 0;
    for (int c = 1; c < 3000 && !fin; c++) begin
      x_valid_i   = $urandom_range(99) < pv;
      shift_req_i = $urandom_range(99) < pr;
      full_i      = rows == wd - 1;
      empty_i     = grants == ((bad > 0) ? bad - 1 : ht - 1);
      start_i     = c == 2;
      if (c == 2) begin cfg_width_i = 1; cfg_tiles_i = 1; end
      if (clr > 0 && in_stream && grants == clr) begin clear_i = 1; shift_req_i = 1; end
      #1;
      if (c == 1) chk("ready_after_start", x_ready_o, 1);
      if (c == 3) begin chk("width_latched", width_o, wd); chk("height_latched", height_o, ht); end
      if (clear_i) begin
        chk("clear_grant", h_shift_o, 1);
        @(negedge clk);
        clear_i = 0; shift_req_i = 0; x_valid_i = 0; start_i = 0;
        #1 chk("clear_outs", outs(), 0);
        fin = 1;
      end else if (done_o || err_o) begin
        fin = 1; t_end = c; got_err = err_o; done_at_end = done_o;
        chk("busy_at_end", busy_o, !err_o);
      end else begin
        chk("setup", pad_setup_o, rows == wd);
        chk("rst_w_index", rst_w_index_o, rows == wd);
        chk("h_shift", h_shift_o, shift_req_i && in_stream);
        chk("shift_gnt", shift_gnt_o, shift_req_i && in_stream);
        chk("x_ready", x_ready_o, !in_stream && rows < wd);
        chk("load", load_o, x_valid_i && !in_stream && rows < wd);
        chk("busy", busy_o, 1);
        if (load_o) begin rows++; n_ld++; end
        if (pad_setup_o) begin rows = 0; in_stream = 1; n_su++; end
        if (h_shift_o) begin
          grants++; n_sh++;
          if (grants == ht) begin grants = 0; in_stream = 0; tiles_done++; end
        end
        @(negedge clk);
      end
    end
    start_i = 0; x_valid_i = 0; shift_req_i = 0;
    if (!fin) chk("timeout", 0, 1);
    else if (clr == 0) begin
      if (bad > 0) begin
        chk("err_pulse", got_err, 1);
        chk("no_done_on_err", done_at_end, 0);
        chk("grants_before_err", n_sh, bad);
      end else begin
        chk("no_err", got_err, 0);
        chk("n_load", n_ld, wd * tl);
        chk("n_shift", n_sh, ht * tl);
        chk("n_setup", n_su, tl);
        chk("tile_cnt", tile_cnt_o, tl);
        if (pv == 100 && pr == 100) chk("done_latency", t_end, tl * (wd + 1 + ht) + 1);
      end
      @(negedge clk);
      #1;
      chk("done_one_cycle", done_o, 0);
      chk("err_one_cycle", err_o, 0);
      chk("idle_after", busy_o, 0);
      if (bad == 0) chk("tile_cnt_hold", tile_cnt_o, tl);
    end
  endtask

  task automatic illegal(input int wd, ht, tl);
    @(negedge clk);
    cfg_width_i = WW'(wd); cfg_height_i = HW'(ht); cfg_tiles_i = TW'(tl); start_i = 1;
    @(negedge clk);
    start_i = 0;
    #1 chk("illegal_err", err_o, 1);
    chk("illegal_busy", busy_o, 0);
    @(negedge clk);
    #1 chk("illegal_err_pulse", err_o, 0);
    chk("illegal_stays_idle", busy_o, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", outs(), 0);
    rst_ni = 1;
    run_job(W, TD, 1, 100, 100, 0, 0);
    run_job(3, 5, 2, 60, 60, 0, 0);
    for (int i = 0; i < 4; i++)
      run_job($urandom_range(1, W), $urandom_range(1, TD), $urandom_range(1, 3),
              $urandom_range(40, 100), $urandom_range(40, 100), 0, 0);
    run_job(1, 1, 3, 100, 100, 0, 0);
    illegal(0, 5, 1);
    illegal(3, TD + 1, 1);
    illegal(3, 5, 0);
    illegal(W + 1, 5, 1);
    run_job(3, 5, 1, 100, 100, 3, 0);
    run_job(3, 5, 1, 100, 100, 0, 2);
    run_job(3, 5, 2, 100, 100, 0, 0);
    @(negedge clk);
    cfg_width_i = WW'(W); cfg_height_i = HW'(TD); cfg_tiles_i = 1; start_i = 1;
    @(negedge clk);
    start_i = 0; x_valid_i = 1; full_i = 0;
    @(posedge clk);
    #2 rst_ni = 0;
    #1 chk("arst_outs", outs(), 0);
    @(negedge clk);
    x_valid_i = 0;
    rst_ni = 1;
    run_job(2, 3, 2, 100, 100, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
